// File: rtl/frac_multiplier.sv
// Sequential shift-add multiplier: 12.12 ratio times 12-bit integer,
// rounded back to a 24-bit integer, with divide-by-zero marker passthrough.
module frac_multiplier #(
    parameter int unsigned ITER     = 12,
    parameter logic [23:0] ERR_CODE = 24'hffffff
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [23:0] s_axis_frac_tdata,
    input  logic        s_axis_frac_tvaild,
    input  logic [11:0] s_axis_mult_tdata,
    input  logic        s_axis_mult_tvaild,
    output logic        s_axis_tready,
    output logic [23:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvaild,
    output logic        m_axis_dout_terr,
    input  logic        m_axis_dout_tready
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ROUND,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [35:0]   a_q, a_d;
    logic [11:0]   b_q, b_d;
    logic [35:0]   acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          tready_q, tready_d;
    logic [23:0]   dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          terr_q, terr_d;

    logic          accept;
    logic [23:0]   rounded;
    logic          unused_lo;

    assign accept    = s_axis_frac_tvaild & s_axis_mult_tvaild & tready_q;
    // Round half up on the first discarded fraction bit.
    assign rounded   = acc_q[35:12] + {23'b0, acc_q[11]};
    assign unused_lo = ^acc_q[10:0];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        dout_d   = dout_q;
        vld_d    = vld_q;
        terr_d   = terr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = {12'b0, s_axis_frac_tdata};
                    b_d     = s_axis_mult_tdata;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = (s_axis_frac_tdata == ERR_CODE);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                dout_d  = err_q ? ERR_CODE : rounded;
                terr_d  = err_q;
                vld_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (m_axis_dout_tready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tready_d = (state_d == IDLE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            tready_q <= 1'b0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            tready_q <= tready_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            terr_q   <= terr_d;
        end
    end

    assign s_axis_tready      = tready_q;
    assign m_axis_dout_tdata  = dout_q;
    assign m_axis_dout_tvaild = vld_q;
    assign m_axis_dout_terr   = terr_q;

endmodule

// File: tb/tb_frac_multiplier.sv
// Bench for frac_multiplier: directed cases, backpressure, reset abort,
// and random operand pairs against an arithmetic reference.
module tb_frac_multiplier;

    logic        aclk = 1'b0;
    logic        areset;
    logic [23:0] frac_tdata;
    logic        frac_tvaild;
    logic [11:0] mult_tdata;
    logic        mult_tvaild;
    logic        s_tready;
    logic [23:0] dout_tdata;
    logic        dout_tvaild;
    logic        dout_terr;
    logic        dout_tready;

    int checks = 0;
    int errors = 0;

    frac_multiplier dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_frac_tdata  (frac_tdata),
        .s_axis_frac_tvaild (frac_tvaild),
        .s_axis_mult_tdata  (mult_tdata),
        .s_axis_mult_tvaild (mult_tvaild),
        .s_axis_tready      (s_tready),
        .m_axis_dout_tdata  (dout_tdata),
        .m_axis_dout_tvaild (dout_tvaild),
        .m_axis_dout_terr   (dout_terr),
        .m_axis_dout_tready (dout_tready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    // Reference: exact product, add half an LSB, truncate the fraction.
    function automatic logic [24:0] model(input logic [23:0] a,
                                          input logic [11:0] b);
        logic [63:0] p;
        if (a == 24'hffffff) return {1'b1, 24'hffffff};
        p = (64'(a) * 64'(b) + 64'd2048) / 64'd4096;
        return {1'b0, p[23:0]};
    endfunction

    task automatic send(input logic [23:0] a, input logic [11:0] b);
        int n = 0;
        while (s_tready !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        chk("accept_ready", 32'(s_tready), 32'd1);
        frac_tdata  = a;
        mult_tdata  = b;
        frac_tvaild = 1'b1;
        mult_tvaild = 1'b1;
        tick;
        frac_tvaild = 1'b0;
        mult_tvaild = 1'b0;
        chk("busy_ready", 32'(s_tready), 32'd0);
    endtask

    task automatic collect(input logic [23:0] a, input logic [11:0] b);
        int lat = 0;
        logic [24:0] e;
        e = model(a, b);
        do begin
            tick;
            lat++;
        end while (dout_tvaild !== 1'b1 && lat < 40);
        chk("latency", 32'(lat), 32'd13);
        chk("tdata", 32'(dout_tdata), 32'(e[23:0]));
        chk("terr", 32'(dout_terr), 32'(e[24]));
    endtask

    task automatic handshake;
        logic [23:0] last;
        last = dout_tdata;
        dout_tready = 1'b1;
        tick;
        chk("vld_drop", 32'(dout_tvaild), 32'd0);
        chk("ready_back", 32'(s_tready), 32'd1);
        chk("tdata_hold", 32'(dout_tdata), 32'(last));
    endtask

    task automatic txn(input logic [23:0] a, input logic [11:0] b,
                       input int hold);
        logic [24:0] e;
        e = model(a, b);
        dout_tready = (hold == 0);
        send(a, b);
        collect(a, b);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk("hold_vld", 32'(dout_tvaild), 32'd1);
            chk("hold_data", 32'(dout_tdata), 32'(e[23:0]));
        end
        handshake;
    endtask

    logic [23:0] a_tab [6] = '{24'h002800, 24'h001555, 24'h010000,
                               24'hfffffe, 24'h123456, 24'h000000};
    logic [11:0] b_tab [6] = '{12'd3, 12'd3, 12'hfff,
                               12'hfff, 12'd0, 12'h7ab};

    initial begin
        logic [24:0] e;
        logic [23:0] ra;
        areset      = 1'b1;
        frac_tdata  = '0;
        frac_tvaild = 1'b0;
        mult_tdata  = '0;
        mult_tvaild = 1'b0;
        dout_tready = 1'b0;
        repeat (3) tick;
        chk("rst_ready", 32'(s_tready), 32'd0);
        chk("rst_vld", 32'(dout_tvaild), 32'd0);
        chk("rst_data", 32'(dout_tdata), 32'd0);
        chk("rst_terr", 32'(dout_terr), 32'd0);
        areset = 1'b0;
        tick;
        chk("post_rst_ready", 32'(s_tready), 32'd1);

        for (int i = 0; i < 6; i++) txn(a_tab[i], b_tab[i], 0);

        // Backpressure with a second pair waiting at the input.
        dout_tready = 1'b0;
        send(24'h002800, 12'd3);
        collect(24'h002800, 12'd3);
        frac_tdata  = 24'h001555;
        mult_tdata  = 12'd3;
        frac_tvaild = 1'b1;
        mult_tvaild = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("bp_vld", 32'(dout_tvaild), 32'd1);
            chk("bp_data", 32'(dout_tdata), 32'h000008);
            chk("bp_terr", 32'(dout_terr), 32'd0);
            chk("bp_ready", 32'(s_tready), 32'd0);
        end
        handshake;
        tick;
        frac_tvaild = 1'b0;
        mult_tvaild = 1'b0;
        chk("bp_accept", 32'(s_tready), 32'd0);
        collect(24'h001555, 12'd3);
        handshake;

        // Only one operand valid: nothing may start.
        dout_tready = 1'b0;
        frac_tdata  = 24'h002800;
        frac_tvaild = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("one_vld_ready", 32'(s_tready), 32'd1);
            chk("one_vld_out", 32'(dout_tvaild), 32'd0);
        end
        frac_tvaild = 1'b0;
        tick;
        chk("one_vld_after", 32'(dout_tvaild), 32'd0);

        // Error marker, then abort a run with reset.
        txn(24'hffffff, 12'd5, 0);
        dout_tready = 1'b1;
        send(24'h002800, 12'd3);
        repeat (6) tick;
        areset = 1'b1;
        tick;
        chk("abort_ready", 32'(s_tready), 32'd0);
        chk("abort_vld", 32'(dout_tvaild), 32'd0);
        chk("abort_data", 32'(dout_tdata), 32'd0);
        chk("abort_terr", 32'(dout_terr), 32'd0);
        areset = 1'b0;
        tick;
        chk("abort_ready_back", 32'(s_tready), 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick;
            chk("abort_no_vld", 32'(dout_tvaild), 32'd0);
        end
        txn(24'h002800, 12'd3, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: ra = 24'hffffff;
                1: ra = 24'hfffffe;
                default: ra = 24'($urandom);
            endcase
            e = model(ra, 12'($urandom));
            txn(ra, 12'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
